// File: rtl/down_counter_modn_pkg.sv
// Shared types and defaults for the mod-N down counter.
// State encoding and clamp ceiling used by the top and its bench.
package down_counter_modn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_MOD    = 9;
  localparam int DEF_MAXVAL = DEF_MOD - 1;

endpackage

// File: rtl/down_count_core.sv
// Count register: synchronous active-low reset, load, enabled decrement,
// plus zero/one detection for the controlling FSM.
module down_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             is_zero,
  output logic             is_one
);

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - WIDTH'(1);
  end

  assign is_zero = (cnt == '0);
  assign is_one  = (cnt == WIDTH'(1));

endmodule

// File: rtl/down_counter_modn.sv
// Loadable mod-N down counter with registered one-cycle terminal-count pulse.
// Define AUTO_RELOAD_EN for periodic reload from the last loaded value.
import down_counter_modn_pkg::*;

module down_counter_modn #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MOD   = DEF_MOD
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] Out,
  output logic             Tc,
  output logic             Busy,
  output logic             Done
);

  localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(MOD - 1);

  state_t           state, state_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             is_zero, is_one;
  logic             core_load, core_dec;
  logic [WIDTH-1:0] core_val;

  assign load_clamped = (LoadVal > MAXVAL) ? MAXVAL : LoadVal;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] rel_reg;

  always_ff @(posedge Clk) begin
    if (!Reset)    rel_reg <= '0;
    else if (Load) rel_reg <= load_clamped;
  end

  // Wrapping past zero reuses the core's load path with the stored period.
  assign core_load = Load | ((state == RUN) & En & is_zero);
  assign core_val  = Load ? load_clamped : rel_reg;
`else
  assign core_load = Load;
  assign core_val  = load_clamped;
`endif

  assign core_dec = (state == RUN) & En & ~is_zero & ~Load;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (core_load),
    .load_val (core_val),
    .dec      (core_dec),
    .cnt      (Out),
    .is_zero  (is_zero),
    .is_one   (is_one)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      Tc    <= 1'b0;
    end else begin
      state <= state_nxt;
      Tc    <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tc_nxt    = 1'b0;
    if (Load) begin
      tc_nxt = (load_clamped == '0);
`ifdef AUTO_RELOAD_EN
      state_nxt = RUN;
`else
      state_nxt = (load_clamped == '0) ? DONE : RUN;
`endif
    end else if (state == RUN && En) begin
`ifdef AUTO_RELOAD_EN
      // A zero period means every enabled edge is a terminal count.
      tc_nxt = is_one | (is_zero & (rel_reg == '0));
`else
      if (is_one) begin
        state_nxt = DONE;
        tc_nxt    = 1'b1;
      end
`endif
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_down_counter_modn.sv
// Scoreboard bench for down_counter_modn: driver queues expected outputs,
// monitor compares one entry after every rising edge.
module tb_down_counter_modn;

  localparam int WIDTH = 4;
  localparam int MOD   = 9;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             En = 1'b0;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] LoadVal = '0;
  logic [WIDTH-1:0] Out;
  logic             Tc, Busy, Done;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  down_counter_modn #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .En      (En),
    .Load    (Load),
    .LoadVal (LoadVal),
    .Out     (Out),
    .Tc      (Tc),
    .Busy    (Busy),
    .Done    (Done)
  );

  always #5 Clk = ~Clk;

  task automatic step(input string name, input logic rst_n, input logic ld,
                      input logic [WIDTH-1:0] val, input logic en,
                      input logic [WIDTH-1:0] e_out, input logic e_tc,
                      input logic e_busy, input logic e_done);
    exp_t e;
    @(negedge Clk);
    Reset = rst_n; Load = ld; LoadVal = val; En = en;
    e.name = name; e.out = e_out; e.tc = e_tc; e.busy = e_busy; e.done = e_done;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a new registered result after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (Out !== e.out || Tc !== e.tc || Busy !== e.busy || Done !== e.done) begin
          miscompares++;
          $display("FAIL %s: got out=%0d tc=%b busy=%b done=%b, want out=%0d tc=%b busy=%b done=%b",
                   e.name, Out, Tc, Busy, Done, e.out, e.tc, e.busy, e.done);
        end
      end
    end
  end

  initial begin
    // name, rst_n, load, val, en -> out, tc, busy, done
    step("reset0", 0, 1, 5, 1, 0, 0, 0, 0);
    step("reset1", 0, 1, 5, 1, 0, 0, 0, 0);
    step("idle_en", 1, 0, 0, 1, 0, 0, 0, 0);
`ifndef AUTO_RELOAD_EN
    step("ld3",      1, 1, 3, 0, 3, 0, 1, 0);
    step("cnt2",     1, 0, 0, 1, 2, 0, 1, 0);
    step("cnt1",     1, 0, 0, 1, 1, 0, 1, 0);
    step("cnt0_tc",  1, 0, 0, 1, 0, 1, 0, 1);
    step("done_hold",1, 0, 0, 1, 0, 0, 0, 1);
    step("done_hold2",1,0, 0, 1, 0, 0, 0, 1);
    step("ld12_clamp",1,1,12, 1, 8, 0, 1, 0);
    step("en1_7",    1, 0, 0, 1, 7, 0, 1, 0);
    step("en0_hold", 1, 0, 0, 0, 7, 0, 1, 0);
    step("en1_6",    1, 0, 0, 1, 6, 0, 1, 0);
    step("cnt5",     1, 0, 0, 1, 5, 0, 1, 0);
    step("cnt4",     1, 0, 0, 1, 4, 0, 1, 0);
    step("ld2_noDec",1, 1, 2, 1, 2, 0, 1, 0);
    step("cnt1b",    1, 0, 0, 1, 1, 0, 1, 0);
    step("midreset", 0, 0, 0, 1, 0, 0, 0, 0);
    step("idle_hold",1, 0, 0, 1, 0, 0, 0, 0);
    step("ld0_tc",   1, 1, 0, 0, 0, 1, 0, 1);
    step("ld0_after",1, 0, 0, 0, 0, 0, 0, 1);
    step("ld1",      1, 1, 1, 1, 1, 0, 1, 0);
    step("ld1_tc",   1, 0, 0, 1, 0, 1, 0, 1);
    step("ld1_after",1, 0, 0, 1, 0, 0, 0, 1);
    step("ld9_clamp",1, 1, 9, 0, 8, 0, 1, 0);
    step("ld8_max",  1, 1, 8, 0, 8, 0, 1, 0);
    step("ld15_clamp",1,1,15, 1, 8, 0, 1, 0);
`else
    step("ar_ld2",   1, 1, 2, 0, 2, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step("ar_cnt1", 1, 0, 0, 1, 1, 0, 1, 0);
      step("ar_cnt0", 1, 0, 0, 1, 0, 1, 1, 0);
      if (k < 2) step("ar_rel2", 1, 0, 0, 1, 2, 0, 1, 0);
    end
    step("ar_hold0", 1, 0, 0, 0, 0, 0, 1, 0);
    step("ar_ld0",   1, 1, 0, 0, 0, 1, 1, 0);
    step("ar_z_tc1", 1, 0, 0, 1, 0, 1, 1, 0);
    step("ar_z_en0", 1, 0, 0, 0, 0, 0, 1, 0);
    step("ar_z_tc2", 1, 0, 0, 1, 0, 1, 1, 0);
    step("ar_ld12",  1, 1,12, 1, 8, 0, 1, 0);
    step("ar_reset", 0, 0, 0, 1, 0, 0, 0, 0);
`endif
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge Clk);
    #2;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0 pending", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
